code_counter: RTL and testbench

//  Two independent 64-bit event counters sharing one enable and a select line.

---
 rtl/code_counter.sv | 61 ++++++
 tb/tb_code_counter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/code_counter.sv
`default_nettype none
// ============================================================================
// code_counter : two 64-bit event counters, one direct and one prescaled by DIV
// Revision     : 1.0
// ============================================================================
module code_counter #(
    parameter int WIDTH = 64,
    parameter int DIV   = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Slt,
    input  logic             En,
    output logic [WIDTH-1:0] Output0,
    output logic [WIDTH-1:0] Output1
);

    localparam int            PW         = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] C_P_LAST   = PW'(DIV - 1);
    localparam logic [PW-1:0] C_P_ONE    = PW'(1);
    localparam logic [WIDTH-1:0] C_ONE   = WIDTH'(1);

    logic [WIDTH-1:0] cnt0_q, cnt0_d;
    logic [WIDTH-1:0] cnt1_q, cnt1_d;
    logic [PW-1:0]    pre_q,  pre_d;

    // Prescaler only advances on counter-1 cycles and is never cleared by a
    // Slt switch, so partial progress survives counter-0 or idle intervals.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        pre_d  = pre_q;
        if (En) begin
            if (!Slt) begin
                cnt0_d = cnt0_q + C_ONE;
            end else if (pre_q == C_P_LAST) begin
                pre_d  = '0;
                cnt1_d = cnt1_q + C_ONE;
            end else begin
                pre_d  = pre_q + C_P_ONE;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
            pre_q  <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
            pre_q  <= pre_d;
        end
    end

    assign Output0 = cnt0_q;
    assign Output1 = cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_code_counter.sv
`default_nettype none
// ============================================================================
// tb_code_counter : directed self-checking bench for code_counter
// Revision        : 1.0
// ============================================================================
module tb_code_counter;

    logic        Clk = 1'b0;
    logic        Reset, Slt, En;
    logic [63:0] Output0, Output1;
    logic        Reset4, Slt4, En4;
    logic [3:0]  Out0_4, Out1_4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    code_counter #(.WIDTH(64), .DIV(4)) u_dut (
        .Clk(Clk), .Reset(Reset), .Slt(Slt), .En(En),
        .Output0(Output0), .Output1(Output1)
    );

    code_counter #(.WIDTH(4), .DIV(4)) u_dut4 (
        .Clk(Clk), .Reset(Reset4), .Slt(Slt4), .En(En4),
        .Output0(Out0_4), .Output1(Out1_4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic rst, input logic slt, input logic en, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            Reset = rst; Slt = slt; En = en;
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic step4(input logic rst, input logic slt, input logic en, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            Reset4 = rst; Slt4 = slt; En4 = en;
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        Reset = 1'b1; Slt = 1'b0; En = 1'b0;
        Reset4 = 1'b1; Slt4 = 1'b0; En4 = 1'b0;

        // 1: reset, then counter 1 steps every 4th edge
        step(1'b1, 1'b1, 1'b1, 1);
        check("rst_o0", Output0, 64'd0);
        check("rst_o1", Output1, 64'd0);
        step(1'b0, 1'b1, 1'b1, 3);
        check("t1_o1_e3", Output1, 64'd0);
        step(1'b0, 1'b1, 1'b1, 1);
        check("t1_o1_e4", Output1, 64'd1);
        step(1'b0, 1'b1, 1'b1, 4);
        check("t1_o1_e8", Output1, 64'd2);
        step(1'b0, 1'b1, 1'b1, 4);
        check("t1_o1_e12", Output1, 64'd3);
        check("t1_o0", Output0, 64'd0);

        // 2: counter 0 counts every enabled edge
        step(1'b1, 1'b0, 1'b1, 1);
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b0, 1'b1, 1);
            check("t2_o0", Output0, 64'(i));
        end
        check("t2_o1", Output1, 64'd0);

        // 3: prescaler retained across a Slt switch
        step(1'b1, 1'b0, 1'b0, 1);
        step(1'b0, 1'b1, 1'b1, 2);
        step(1'b0, 1'b0, 1'b1, 3);
        step(1'b0, 1'b1, 1'b1, 1);
        check("t3_o1_mid", Output1, 64'd0);
        step(1'b0, 1'b1, 1'b1, 1);
        check("t3_o0", Output0, 64'd3);
        check("t3_o1", Output1, 64'd1);

        // 4: En=0 freezes everything including the prescaler (p=3 here)
        step(1'b0, 1'b1, 1'b1, 3);
        check("t4_pre_o1", Output1, 64'd1);
        step(1'b0, 1'b1, 1'b0, 2);
        step(1'b0, 1'b0, 1'b0, 3);
        check("t4_hold_o0", Output0, 64'd3);
        check("t4_hold_o1", Output1, 64'd1);
        step(1'b0, 1'b1, 1'b1, 1);
        check("t4_resume_o1", Output1, 64'd2);
        step(1'b0, 1'b0, 1'b1, 1);
        check("t4_resume_o0", Output0, 64'd4);

        // 5: reset mid-count discards prescale progress
        step(1'b1, 1'b0, 1'b0, 1);
        step(1'b0, 1'b0, 1'b1, 7);
        check("t5_o0_pre", Output0, 64'd7);
        step(1'b0, 1'b1, 1'b1, 3);
        step(1'b1, 1'b1, 1'b1, 1);
        check("t5_rst_o0", Output0, 64'd0);
        check("t5_rst_o1", Output1, 64'd0);
        step(1'b0, 1'b1, 1'b1, 3);
        check("t5_o1_e3", Output1, 64'd0);
        step(1'b0, 1'b1, 1'b1, 1);
        check("t5_o1_e4", Output1, 64'd1);

        // 6: wrap-around on the narrow instance
        step4(1'b1, 1'b0, 1'b0, 1);
        check("t6_rst", 64'(Out0_4), 64'd0);
        step4(1'b0, 1'b0, 1'b1, 15);
        check("t6_full", 64'(Out0_4), 64'hF);
        step4(1'b0, 1'b0, 1'b1, 1);
        check("t6_wrap", 64'(Out0_4), 64'd0);
        check("t6_o1", 64'(Out1_4), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
